// File: rtl/ball_motion_if.sv
// Ball motion bus: play controls and paddle positions in, ball state and score pulses out.
interface ball_motion_if;
    logic       game_on;
    logic [1:0] diff;
    logic [9:0] left_pos;
    logic [9:0] right_pos;
    logic [9:0] ballX;
    logic [9:0] ballY;
    logic       moving_up;
    logic       moving_down;
    logic       serving;
    logic       score_left;
    logic       score_right;

    modport master (
        output game_on, diff, left_pos, right_pos,
        input  ballX, ballY, moving_up, moving_down, serving, score_left, score_right
    );

    modport slave (
        input  game_on, diff, left_pos, right_pos,
        output ballX, ballY, moving_up, moving_down, serving, score_left, score_right
    );
endinterface

// File: rtl/ball_motion.sv
// Pong ball mover: difficulty-paced step strobe, wall/paddle bounces, miss scoring and re-serve.
// Optional macro BALL_SPEEDUP_EN: paddle hits shorten the step period; period reloads only while serving.
module ball_motion #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_XL   = 16,
    parameter int PADDLE_XR   = 616,
    parameter int TICKS_D0    = 80000,
    parameter int TICKS_D1    = 60000,
    parameter int TICKS_D2    = 40000,
    parameter int TICKS_D3    = 20000,
    parameter int SERVE_STEPS = 64
) (
    input  logic          clk,
    input  logic          reset,
    ball_motion_if.slave  bm
);
    localparam int TMAX01 = (TICKS_D0 > TICKS_D1) ? TICKS_D0 : TICKS_D1;
    localparam int TMAX23 = (TICKS_D2 > TICKS_D3) ? TICKS_D2 : TICKS_D3;
    localparam int TMAX   = (TMAX01 > TMAX23) ? TMAX01 : TMAX23;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int SW     = $clog2(SERVE_STEPS + 1);

    localparam logic [9:0]  CX     = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  CY     = 10'(SCREEN_H / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  X_MAX  = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0]  Y_MAX  = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]  X_LHIT = 10'(PADDLE_XL + PADDLE_W);
    localparam logic [9:0]  X_RHIT = 10'(PADDLE_XR - BALL_SIZE);
    localparam logic [10:0] BS11   = 11'(BALL_SIZE);
    localparam logic [10:0] PH11   = 11'(PADDLE_H);

    typedef enum logic [1:0] {SERVE, PLAY, SCORED} state_t;

    state_t          state, state_d;
    logic [9:0]      ball_x, ball_x_d, ball_y, ball_y_d;
    logic            dir_left, dir_left_d, up, up_d;
    logic            serving, serving_d, score_l, score_l_d, score_r, score_r_d;
    logic [SW-1:0]   step_cnt, step_cnt_d;
    logic [TW-1:0]   tick_cnt, period_q, period_eff;
    logic            strobe, ov_l, ov_r, hit_l, hit_r, miss_l, miss_r;

    function automatic logic [TW-1:0] ticks_for(input logic [1:0] d);
        case (d)
            2'b00:   return TW'(TICKS_D0);
            2'b01:   return TW'(TICKS_D1);
            2'b10:   return TW'(TICKS_D2);
            default: return TW'(TICKS_D3);
        endcase
    endfunction

    // diff is looked at only at the first count of an interval; the rest of the interval uses period_q
`ifdef BALL_SPEEDUP_EN
    assign period_eff = (state == SERVE && tick_cnt == '0) ? ticks_for(bm.diff) : period_q;
`else
    assign period_eff = (tick_cnt == '0) ? ticks_for(bm.diff) : period_q;
`endif
    assign strobe = bm.game_on && (tick_cnt == period_eff - TW'(1));

    assign ov_l  = ({1'b0, ball_y} + BS11 > {1'b0, bm.left_pos})  && ({1'b0, ball_y} < {1'b0, bm.left_pos} + PH11);
    assign ov_r  = ({1'b0, ball_y} + BS11 > {1'b0, bm.right_pos}) && ({1'b0, ball_y} < {1'b0, bm.right_pos} + PH11);
    assign hit_l = (state == PLAY) && dir_left  && ball_x == X_LHIT && ov_l;
    assign hit_r = (state == PLAY) && !dir_left && ball_x == X_RHIT && ov_r;
    assign miss_l = dir_left  && ball_x == '0;
    assign miss_r = !dir_left && ball_x == X_MAX;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            period_q <= TW'(TICKS_D0);
        end else if (bm.game_on) begin
            tick_cnt <= strobe ? '0 : tick_cnt + TW'(1);
`ifdef BALL_SPEEDUP_EN
            if (strobe && (hit_l || hit_r)) begin
                if (period_eff - (period_eff >> 4) < TW'(TICKS_D3 / 2))
                    period_q <= TW'(TICKS_D3 / 2);
                else
                    period_q <= period_eff - (period_eff >> 4);
            end else begin
                period_q <= period_eff;
            end
`else
            period_q <= period_eff;
`endif
        end
    end

    // Freezing falls out of strobe gating; SCORED exits regardless of game_on so the pulse stays one clk
    always_comb begin
        state_d    = state;
        ball_x_d   = ball_x;
        ball_y_d   = ball_y;
        dir_left_d = dir_left;
        up_d       = up;
        serving_d  = serving;
        score_l_d  = 1'b0;
        score_r_d  = 1'b0;
        step_cnt_d = step_cnt;
        unique case (state)
            SERVE: begin
                if (strobe) begin
                    if (step_cnt == SW'(SERVE_STEPS - 1)) begin
                        state_d    = PLAY;
                        serving_d  = 1'b0;
                        step_cnt_d = '0;
                    end else begin
                        step_cnt_d = step_cnt + SW'(1);
                    end
                end
            end
            PLAY: begin
                if (strobe) begin
                    if (miss_l) begin
                        state_d   = SCORED;
                        score_r_d = 1'b1;
                    end else if (miss_r) begin
                        state_d   = SCORED;
                        score_l_d = 1'b1;
                    end else begin
                        if (up && ball_y == '0)
                            up_d = 1'b0;
                        else if (!up && ball_y == Y_MAX)
                            up_d = 1'b1;
                        if (hit_l)
                            dir_left_d = 1'b0;
                        else if (hit_r)
                            dir_left_d = 1'b1;
                        ball_x_d = dir_left_d ? ball_x - 10'd1 : ball_x + 10'd1;
                        ball_y_d = up_d ? ball_y - 10'd1 : ball_y + 10'd1;
                    end
                end
            end
            SCORED: begin
                state_d    = SERVE;
                ball_x_d   = CX;
                ball_y_d   = CY;
                serving_d  = 1'b1;
                step_cnt_d = '0;
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= SERVE;
            ball_x   <= CX;
            ball_y   <= CY;
            dir_left <= 1'b0;
            up       <= 1'b0;
            serving  <= 1'b1;
            score_l  <= 1'b0;
            score_r  <= 1'b0;
            step_cnt <= '0;
        end else begin
            state    <= state_d;
            ball_x   <= ball_x_d;
            ball_y   <= ball_y_d;
            dir_left <= dir_left_d;
            up       <= up_d;
            serving  <= serving_d;
            score_l  <= score_l_d;
            score_r  <= score_r_d;
            step_cnt <= step_cnt_d;
        end
    end

    assign bm.ballX       = ball_x;
    assign bm.ballY       = ball_y;
    assign bm.moving_up   = up;
    assign bm.moving_down = ~up;
    assign bm.serving     = serving;
    assign bm.score_left  = score_l;
    assign bm.score_right = score_r;
endmodule
